// File: rtl/odometria_robo.sv
// Grid odometry for the robot: integrates move/rotate/remove pulses into position,
// saturating activity counters, stuck detection and an optional position history.
// Optional history ring buffer is built only when ODOMETRIA_HIST_EN is defined.
module odometria_robo #(
  parameter int unsigned MAP_W     = 16,
  parameter int unsigned MAP_H     = 16,
  parameter int unsigned X0        = 0,
  parameter int unsigned Y0        = 0,
  parameter int unsigned STUCK_LIM = 4,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned XW       = $clog2(MAP_W),
  localparam int unsigned YW       = $clog2(MAP_H)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             avancar,
  input  logic             girar,
  input  logic             remover,
  input  logic [2:0]       orientacao,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic [CNT_W-1:0] passos,
  output logic [CNT_W-1:0] giros,
  output logic [CNT_W-1:0] removidos,
  output logic             erro_mov,
  output logic             preso,
  output logic             no_inicio,
  input  logic [2:0]       hist_idx,
  output logic [XW-1:0]    hist_x,
  output logic [YW-1:0]    hist_y,
  output logic             hist_valid
);

  localparam int unsigned SW = $clog2(STUCK_LIM + 1);
  localparam logic [XW-1:0] X_MAX   = XW'(MAP_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(MAP_H - 1);
  localparam logic [XW-1:0] X_START = XW'(X0);
  localparam logic [YW-1:0] Y_START = YW'(Y0);
  localparam logic [SW-1:0] S_LIM   = SW'(STUCK_LIM);

  typedef enum logic [1:0] {
    PARADO,
    ANDANDO,
    GIRANDO,
    PRESO
  } estado_t;

  estado_t          state_q, state_d;
  logic [XW-1:0]    pos_x_q, pos_x_d;
  logic [YW-1:0]    pos_y_q, pos_y_d;
  logic [CNT_W-1:0] passos_q, passos_d;
  logic [CNT_W-1:0] giros_q, giros_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [SW-1:0]    stuck_q, stuck_d;
  logic             erro_q, erro_d;

  logic blocked;
  logic move_ok;
  logic rot_ok;

  // A move is legal only alone, with a valid heading and a target inside the map.
  always_comb begin
    blocked = 1'b0;
    case (orientacao[1:0])
      2'd0:    blocked = (pos_y_q == Y_MAX);
      2'd1:    blocked = (pos_x_q == X_MAX);
      2'd2:    blocked = (pos_y_q == '0);
      default: blocked = (pos_x_q == '0);
    endcase
    move_ok = avancar & ~girar & ~orientacao[2] & ~blocked;
    rot_ok  = girar & ~avancar;
  end

  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    passos_d = passos_q;
    giros_d  = giros_q;
    rem_d    = rem_q;
    stuck_d  = stuck_q;
    erro_d   = avancar & ~move_ok;

    if (move_ok) begin
      case (orientacao[1:0])
        2'd0:    pos_y_d = pos_y_q + YW'(1);
        2'd1:    pos_x_d = pos_x_q + XW'(1);
        2'd2:    pos_y_d = pos_y_q - YW'(1);
        default: pos_x_d = pos_x_q - XW'(1);
      endcase
      stuck_d = '0;
      if (passos_q != '1) passos_d = passos_q + CNT_W'(1);
    end else if (rot_ok) begin
      if (giros_q != '1) giros_d = giros_q + CNT_W'(1);
      if (stuck_q != S_LIM) stuck_d = stuck_q + SW'(1);
    end

    if (remover && rem_q != '1) rem_d = rem_q + CNT_W'(1);
  end

  // With STUCK_LIM==1 a single rotation from a moving/idle state already means stuck.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PARADO, ANDANDO: begin
        if (move_ok)     state_d = ANDANDO;
        else if (rot_ok) state_d = (stuck_d == S_LIM) ? PRESO : GIRANDO;
      end
      GIRANDO: begin
        if (move_ok)                          state_d = ANDANDO;
        else if (rot_ok && stuck_d == S_LIM)  state_d = PRESO;
      end
      PRESO: begin
        if (move_ok) state_d = ANDANDO;
      end
      default: state_d = PARADO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= PARADO;
      pos_x_q  <= X_START;
      pos_y_q  <= Y_START;
      passos_q <= '0;
      giros_q  <= '0;
      rem_q    <= '0;
      stuck_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      passos_q <= passos_d;
      giros_q  <= giros_d;
      rem_q    <= rem_d;
      stuck_q  <= stuck_d;
      erro_q   <= erro_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign passos    = passos_q;
  assign giros     = giros_q;
  assign removidos = rem_q;
  assign erro_mov  = erro_q;
  assign preso     = (state_q == PRESO);
  assign no_inicio = (pos_x_q == X_START) && (pos_y_q == Y_START);

`ifdef ODOMETRIA_HIST_EN
  localparam int unsigned HIST_D = 8;

  logic [XW-1:0] hbuf_x_q [HIST_D];
  logic [YW-1:0] hbuf_y_q [HIST_D];
  logic [2:0]    wr_ptr_q;
  logic [3:0]    fill_q;
  logic [2:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < HIST_D; i++) begin
        hbuf_x_q[i[2:0]] <= '0;
        hbuf_y_q[i[2:0]] <= '0;
      end
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (move_ok) begin
      hbuf_x_q[wr_ptr_q] <= pos_x_q;
      hbuf_y_q[wr_ptr_q] <= pos_y_q;
      wr_ptr_q <= wr_ptr_q + 3'd1;
      if (fill_q != 4'd8) fill_q <= fill_q + 4'd1;
    end
  end

  // Index 0 is the slot just behind the write pointer (most recent push).
  assign rd_ptr     = wr_ptr_q - 3'd1 - hist_idx;
  assign hist_x     = hbuf_x_q[rd_ptr];
  assign hist_y     = hbuf_y_q[rd_ptr];
  assign hist_valid = ({1'b0, hist_idx} < fill_q);
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_x     = '0;
  assign hist_y     = '0;
  assign hist_valid = 1'b0;
`endif

endmodule
